fetch_queue_ctrl: RTL
=====================

Name: fetch_queue_ctrl

Overview:
- Fetch-stage sequencer for the byte-addressed, 32-bit-read instruction ROM at 0xBFC00000..0xBFC00FFF.
- Owns the fetch PC, drives the ROM address, and captures {pc, instr} pairs into a small in-order queue that decode drains with a valid/ready handshake.
- Handles decode back-pressure, branch/jump redirect (flush), and out-of-range or misaligned fetch addresses.

Parameters:
- ADDR_WIDTH, 32, width of the PC and ROM address.
- DEPTH, 4, number of queue entries; must be a power of two, ≥2.
- RESET_PC, 32'hBFC00000, fetch PC loaded on reset.
- ROM_BASE, 32'hBFC00000, lowest legal fetch byte address.
- ROM_LAST, 32'hBFC00FFC, highest legal word-aligned fetch address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_WIDTH  byte address to the ROM; equals fetch_pc combinationally.
- imem_rd  in  32  ROM read data; combinational, valid in the same cycle as imem_addr.
- redirect_en  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  new fetch target.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction word.
- out_pc  out  ADDR_WIDTH  head instruction address.
- out_pc_plus4  out  ADDR_WIDTH  out_pc + 4, modulo 2^ADDR_WIDTH.
- count  out  $clog2(DEPTH)+1  current occupancy.
- fault  out  1  fetch halted on an illegal fetch_pc.

Behaviour:
- State:
  - fetch_pc register.
  - Circular buffer of DEPTH entries {pc, instr}.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping at DEPTH.
  - count register.
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC; wr_ptr=rd_ptr=0; count=0.
  - Resulting outputs: out_valid=0, fault=0, imem_addr=RESET_PC.
  - Buffer contents are don't-care; out_instr and out_pc are don't-care while out_valid=0.
  - rst overrides redirect_en and all handshakes. Reset mid-stream discards all entries.
- legal = (fetch_pc[1:0]==0) && (fetch_pc ≥ ROM_BASE) && (fetch_pc ≤ ROM_LAST).
- fault = ~legal, combinational from fetch_pc.
- deq = out_valid && out_ready.
- out_valid = (count≠0) && ~redirect_en.
- enq = legal && ~redirect_en && (count<DEPTH || deq). An enqueue is allowed into a full queue when a dequeue happens in the same cycle.
- On enq: buffer[wr_ptr]={fetch_pc, imem_rd}; wr_ptr+1; fetch_pc+=4. Fetch latency is zero wait states, so an instruction appears at the head one cycle after its address is driven, if the queue was empty.
- On deq: rd_ptr+1.
- count update: +1 on enq only, −1 on deq only, unchanged when both or neither occur.
- Full queue with no deq: fetch_pc holds and imem_addr is stable.
- Illegal fetch_pc:
  - No enqueue; fetch_pc holds.
  - Queue keeps draining normally.
  - fault stays 1 until a redirect loads a legal PC.
- PC arithmetic is unsigned modulo 2^ADDR_WIDTH. Wrapping past ROM_LAST produces an illegal PC, which faults.
- Redirect (redirect_en=1, rst=0):
  - Next cycle: wr_ptr=rd_ptr=0, count=0, fetch_pc=redirect_pc.
  - No enq and no deq in the redirect cycle; out_valid is forced 0, so decode cannot consume a stale entry.
  - A misaligned or out-of-range redirect_pc raises fault from the next cycle.
  - Back-to-back redirects: the last one wins; each flushes.
- Output mux: out_instr, out_pc and out_pc_plus4 come from buffer[rd_ptr] combinationally; there is no registered output stage.
- Invariants:
  - 0 ≤ count ≤ DEPTH.
  - wr_ptr − rd_ptr ≡ count (mod DEPTH).
  - Entries leave in fetch order.

Test Plan:
- Reset then free-run, out_ready=1, ROM words W0..W3 at 0xBFC00000..0xBFC0000C:
  - cycle 1: out_valid=1, out_pc=0xBFC00000, out_instr=W0, out_pc_plus4=0xBFC00004;
  - then one instruction per cycle in order; count stays 1.
- out_ready=0 from reset:
  - count climbs 1,2,3,4 and stops; imem_addr holds 0xBFC00010; head stays W0.
  - Raising out_ready then yields W0,W1,W2,W3,W4 on consecutive cycles with count=4 throughout (simultaneous enq and deq).
- Redirect with count=3 and redirect_pc=0xBFC00100:
  - redirect cycle: out_valid=0;
  - next cycle: count=0, imem_addr=0xBFC00100;
  - following cycle: out_pc=0xBFC00100.
- Fetch runs to ROM_LAST with out_ready=1:
  - last entry out_pc=0xBFC00FFC; fetch_pc=0xBFC01000; fault=1; no further entries; count drains to 0.
  - Redirect to 0xBFC00000 clears fault.
- Redirect to 0xBFC00002 (misaligned) and to 0x00000000:
  - fault=1 next cycle; out_valid stays 0; count=0.
- Assert rst mid-stream with count=2 and redirect_en=1 in the same cycle:
  - next cycle: count=0, imem_addr=RESET_PC, fault=0 (reset priority).

Source files
------------

// File: rtl/fetch_queue_ctrl_if.sv
// Fetch-to-ROM and fetch-to-decode signal bundle for fetch_queue_ctrl.
// master = the fetch controller, slave = ROM/decode/branch environment.
interface fetch_queue_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_rd;
  logic                  redirect_en;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [ADDR_WIDTH-1:0] out_pc_plus4;
  logic [CW-1:0]         count;
  logic                  fault;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_en,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    output count,
    output fault
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_en,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    input  count,
    input  fault
  );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the boot ROM with zero wait states
// and queues {pc, instr} pairs in order for decode; supports redirect flush.
module fetch_queue_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 32'hBFC00000,
  parameter logic [ADDR_WIDTH-1:0] ROM_LAST   = 32'hBFC00FFC
) (
  input logic              clk,
  input logic              rst,
  fetch_queue_ctrl_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] mem_pc    [DEPTH];
  logic [31:0]           mem_instr [DEPTH];

  logic legal;
  logic full;
  logic valid;
  logic deq;
  logic enq;

  always_comb begin
    legal = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= ROM_BASE) && (fetch_pc <= ROM_LAST);
    full  = (count == CW'(DEPTH));
    valid = (count != '0) && !bus.redirect_en;
    deq   = valid && bus.out_ready;
    // A full queue still accepts a new word when the head leaves this cycle.
    enq   = legal && !bus.redirect_en && (!full || deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_en) begin
      fetch_pc <= bus.redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (enq && !deq) begin
        count <= count + CW'(1);
      end else if (deq && !enq) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage carries no reset; entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      mem_pc[wr_ptr]    <= fetch_pc;
      mem_instr[wr_ptr] <= bus.imem_rd;
    end
  end

  always_comb begin
    bus.imem_addr    = fetch_pc;
    bus.out_valid    = valid;
    bus.out_instr    = mem_instr[rd_ptr];
    bus.out_pc       = mem_pc[rd_ptr];
    bus.out_pc_plus4 = mem_pc[rd_ptr] + ADDR_WIDTH'(4);
    bus.count        = count;
    bus.fault        = !legal;
  end
endmodule
